// File: rtl/uart_rx.sv
// uart_rx: 8N1 serial receiver, LSB first, fixed baud derived from the system clock.
// The asynchronous Rx line is synchronized, a start edge is qualified at mid start bit,
// and every following bit (data and stop) is sampled at mid-bit. A good frame updates
// RxData with a one-cycle RxValid strobe; a low stop bit gives a one-cycle RxFrameError
// and leaves RxData untouched.
//
// state | meaning
// IDLE  | line idle, counter held at 0, waiting for a high-to-low edge on rx_s
// START | timing half a bit to re-check the start bit (a high sample means glitch)
// DATA  | sampling 8 data bits at mid-bit, LSB first
// STOP  | sampling the stop bit, then strobe RxValid or RxFrameError
module uart_rx #(
    parameter int CLK_RATE  = 100000000,
    parameter int BAUD_RATE = 115200
) (
    input  logic       Clk,
    input  logic       Reset,
    input  logic       Rx,
    output logic [7:0] RxData,
    output logic       RxValid,
    output logic       RxFrameError,
    output logic       RxBusy
);

    localparam int CLKS_PER_BIT = CLK_RATE / BAUD_RATE;
    localparam int HALF_BIT     = CLKS_PER_BIT / 2;

    // Terminal counts; HALF_BIT must be at least 1, i.e. CLK_RATE >= 2*BAUD_RATE.
    localparam logic [31:0] BIT_LAST  = 32'(CLKS_PER_BIT - 1);
    localparam logic [31:0] HALF_LAST = 32'(HALF_BIT - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } state_t;

    state_t      state_q, state_d;
    logic        sync1_q;
    logic        rx_s_q;
    logic        rx_d_q;
    logic [31:0] cnt_q, cnt_d;
    logic [2:0]  bit_idx_q, bit_idx_d;
    logic [7:0]  shift_q, shift_d;
    logic [7:0]  data_q, data_d;
    logic        valid_q, valid_d;
    logic        ferr_q, ferr_d;

    // Two-flop synchronizer plus one delayed copy for edge detection; idle-high reset.
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            sync1_q <= 1'b1;
            rx_s_q  <= 1'b1;
            rx_d_q  <= 1'b1;
        end else begin
            sync1_q <= Rx;
            rx_s_q  <= sync1_q;
            rx_d_q  <= rx_s_q;
        end
    end

    // State, timing and datapath registers.
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state_q   <= IDLE;
            cnt_q     <= 32'd0;
            bit_idx_q <= 3'd0;
            shift_q   <= 8'h00;
            data_q    <= 8'h00;
            valid_q   <= 1'b0;
            ferr_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            bit_idx_q <= bit_idx_d;
            shift_q   <= shift_d;
            data_q    <= data_d;
            valid_q   <= valid_d;
            ferr_q    <= ferr_d;
        end
    end

    // Next-state, bit timing and strobe generation.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        bit_idx_d = bit_idx_q;
        shift_d   = shift_q;
        data_d    = data_q;
        valid_d   = 1'b0;
        ferr_d    = 1'b0;

        unique case (state_q)
            IDLE: begin
                cnt_d = 32'd0;
                // A genuine falling edge is required, so a line held low after a
                // frame error (break) cannot restart reception.
                if (rx_d_q && !rx_s_q) begin
                    state_d = START;
                end
            end

            START: begin
                if (cnt_q == HALF_LAST) begin
                    cnt_d = 32'd0;
                    if (!rx_s_q) begin
                        bit_idx_d = 3'd0;
                        state_d   = DATA;
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    cnt_d = cnt_q + 32'd1;
                end
            end

            DATA: begin
                if (cnt_q == BIT_LAST) begin
                    cnt_d   = 32'd0;
                    shift_d = {rx_s_q, shift_q[7:1]};
                    if (bit_idx_q == 3'd7) begin
                        state_d = STOP;
                    end else begin
                        bit_idx_d = bit_idx_q + 3'd1;
                    end
                end else begin
                    cnt_d = cnt_q + 32'd1;
                end
            end

            STOP: begin
                if (cnt_q == BIT_LAST) begin
                    cnt_d   = 32'd0;
                    state_d = IDLE;
                    if (rx_s_q) begin
                        data_d  = shift_q;
                        valid_d = 1'b1;
                    end else begin
                        ferr_d = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + 32'd1;
                end
            end

            default: begin
                state_d = IDLE;
                cnt_d   = 32'd0;
            end
        endcase
    end

    assign RxData       = data_q;
    assign RxValid      = valid_q;
    assign RxFrameError = ferr_q;
    assign RxBusy       = (state_q != IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: directed frames into uart_rx with a frame-timeline reference model
// checked every cycle, plus literal expectations for counts, data and latency.
`timescale 1ns/1ps
module tb_uart_rx;

    localparam int CLK_RATE  = 5000;
    localparam int BAUD_RATE = 100;
    localparam int CPB       = CLK_RATE / BAUD_RATE;   // 50
    localparam int HALF      = CPB / 2;                // 25
    localparam int HIST      = 32768;

    logic       Clk   = 1'b0;
    logic       Reset = 1'b0;
    logic       Rx    = 1'b1;
    logic [7:0] RxData;
    logic       RxValid;
    logic       RxFrameError;
    logic       RxBusy;

    uart_rx #(.CLK_RATE(CLK_RATE), .BAUD_RATE(BAUD_RATE)) dut (
        .Clk         (Clk),
        .Reset       (Reset),
        .Rx          (Rx),
        .RxData      (RxData),
        .RxValid     (RxValid),
        .RxFrameError(RxFrameError),
        .RxBusy      (RxBusy)
    );

    always #5 Clk = ~Clk;

    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // rx_at[t] is the line value seen at rising edge t (forced to 1 while in reset,
    // matching the synchronizer reset). The receiver sees that value two edges later.
    bit         rx_at [0:HIST-1];
    int         cyc = 3;
    bit         m_busy = 1'b0;
    int         m_e = 0;
    logic [7:0] m_byte = 8'h00;
    bit         exp_valid = 1'b0;
    bit         exp_ferr  = 1'b0;
    logic [7:0] exp_data  = 8'h00;

    initial begin
        for (int i = 0; i < HIST; i++) rx_at[i] = 1'b1;
    end

    always @(posedge Clk) begin
        int rel;
        int k;
        cyc++;
        if (cyc >= HIST) begin
            $display("FAIL model_history actual=%0d expected=<%0d", cyc, HIST);
            $fatal(1, "history exhausted");
        end
        exp_valid = 1'b0;
        exp_ferr  = 1'b0;
        if (!Reset) begin
            rx_at[cyc]   = 1'b1;
            rx_at[cyc-1] = 1'b1;
            rx_at[cyc-2] = 1'b1;
            m_busy       = 1'b0;
            exp_data     = 8'h00;
        end else begin
            rx_at[cyc] = Rx;
            if (!m_busy) begin
                if (rx_at[cyc-3] && !rx_at[cyc-2]) begin
                    m_busy = 1'b1;
                    m_e    = cyc;
                end
            end else begin
                rel = cyc - m_e - HALF;
                if (rel == 0) begin
                    if (rx_at[cyc-2]) m_busy = 1'b0;
                end else if (rel > 0 && (rel % CPB) == 0) begin
                    k = rel / CPB;
                    if (k <= 8) begin
                        m_byte[k-1] = rx_at[cyc-2];
                    end else begin
                        if (rx_at[cyc-2]) begin
                            exp_valid = 1'b1;
                            exp_data  = m_byte;
                        end else begin
                            exp_ferr = 1'b1;
                        end
                        m_busy = 1'b0;
                    end
                end
            end
        end
    end

    // ---------------- per-cycle compare and event log ----------------
    int         vcount = 0;
    int         fcount = 0;
    int         busy_cnt = 0;
    int         last_vcyc = 0;
    int         fall_cyc = 0;
    logic [7:0] vq[$];

    always @(negedge Clk) begin
        if (cyc > 4) begin
            chk("cyc_valid", int'(RxValid), int'(exp_valid));
            chk("cyc_ferr", int'(RxFrameError), int'(exp_ferr));
            chk("cyc_busy", int'(RxBusy), int'(m_busy));
            chk("cyc_data", int'(RxData), int'(exp_data));
        end
        if (RxValid) begin
            vcount++;
            vq.push_back(RxData);
            last_vcyc = cyc;
        end
        if (RxFrameError) fcount++;
        if (RxBusy) busy_cnt++;
    end

    // ---------------- stimulus ----------------
    task automatic idle(input int n);
        repeat (n) @(negedge Clk);
    endtask

    task automatic send(input logic [7:0] b, input int bit_clks, input bit stop_val);
        Rx = 1'b0;
        fall_cyc = cyc;
        idle(bit_clks);
        for (int i = 0; i < 8; i++) begin
            Rx = b[i];
            idle(bit_clks);
        end
        Rx = stop_val;
        idle(bit_clks);
        Rx = 1'b1;
    endtask

    int v0, f0, b0, q0;
    logic [7:0] partial;

    initial begin
        Reset = 1'b0;
        Rx    = 1'b1;
        idle(4);
        chk("rst_data", int'(RxData), 0);
        chk("rst_valid", int'(RxValid), 0);
        chk("rst_ferr", int'(RxFrameError), 0);
        chk("rst_busy", int'(RxBusy), 0);
        Reset = 1'b1;
        idle(20);

        // single frame, exact baud
        v0 = vcount; f0 = fcount;
        send(8'h41, CPB, 1'b1);
        idle(60);
        chk("a41_count", vcount - v0, 1);
        chk("a41_data", int'(RxData), 'h41);
        chk("a41_ferr", fcount - f0, 0);
        // 2 sync + HALF + 9*CPB + 1 = 478
        chk("a41_latency", last_vcyc - fall_cyc, 478);

        // back-to-back, no idle gap
        v0 = vcount; q0 = vq.size();
        send(8'h00, CPB, 1'b1);
        send(8'hFF, CPB, 1'b1);
        send(8'hA5, CPB, 1'b1);
        idle(60);
        chk("b2b_count", vcount - v0, 3);
        if (vq.size() >= q0 + 3) begin
            chk("b2b_data0", int'(vq[q0]), 'h00);
            chk("b2b_data1", int'(vq[q0+1]), 'hFF);
            chk("b2b_data2", int'(vq[q0+2]), 'hA5);
        end

        // short low pulse: rejected at mid start bit
        v0 = vcount; f0 = fcount; b0 = busy_cnt;
        Rx = 1'b0;
        idle(10);
        Rx = 1'b1;
        idle(60);
        chk("glitch_valid", vcount - v0, 0);
        chk("glitch_ferr", fcount - f0, 0);
        chk("glitch_busy_cycles", busy_cnt - b0, 25);
        send(8'h3C, CPB, 1'b1);
        idle(60);
        chk("a3c_count", vcount - v0, 1);
        chk("a3c_data", int'(RxData), 'h3C);

        // stop bit low followed by a long break
        v0 = vcount; f0 = fcount;
        send(8'h55, CPB, 1'b0);
        Rx = 1'b0;
        idle(20 * CPB);
        Rx = 1'b1;
        idle(100);
        chk("break_ferr", fcount - f0, 1);
        chk("break_valid", vcount - v0, 0);
        chk("break_data_held", int'(RxData), 'h3C);
        send(8'h12, CPB, 1'b1);
        idle(60);
        chk("a12_count", vcount - v0, 1);
        chk("a12_data", int'(RxData), 'h12);

        // reset during data bit 4
        v0 = vcount; f0 = fcount;
        partial = 8'h99;
        Rx = 1'b0;
        idle(CPB);
        for (int i = 0; i < 4; i++) begin
            Rx = partial[i];
            idle(CPB);
        end
        Rx = partial[4];
        idle(HALF);
        #2 Reset = 1'b0;
        idle(3);
        chk("midrst_data", int'(RxData), 0);
        chk("midrst_busy", int'(RxBusy), 0);
        chk("midrst_valid", int'(RxValid), 0);
        Rx = 1'b1;
        idle(2);
        Reset = 1'b1;
        idle(100);
        chk("midrst_no_valid", vcount - v0, 0);
        chk("midrst_no_ferr", fcount - f0, 0);
        send(8'h7E, CPB, 1'b1);
        idle(60);
        chk("a7e_count", vcount - v0, 1);
        chk("a7e_data", int'(RxData), 'h7E);

        // transmitter baud +2% slow (51 clocks/bit) and -2% fast (49 clocks/bit)
        v0 = vcount; f0 = fcount;
        send(8'hC3, CPB + 1, 1'b1);
        idle(60);
        chk("c3_slow_count", vcount - v0, 1);
        chk("c3_slow_data", int'(RxData), 'hC3);
        send(8'h00, CPB, 1'b1);
        idle(60);
        v0 = vcount;
        send(8'hC3, CPB - 1, 1'b1);
        idle(60);
        chk("c3_fast_count", vcount - v0, 1);
        chk("c3_fast_data", int'(RxData), 'hC3);
        chk("c3_ferr", fcount - f0, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
